// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the Gray count sequencer: FSM state encoding,
// the default counter width and the binary-to-Gray conversion.
package gray_seq_pkg;

    localparam int GRAY_W     = 4;
    localparam int GRAY_MAX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Operates at the widest legal width; callers zero-extend and truncate.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_count_sequencer_gray2bin.sv
// Gray-to-binary converter: prefix XOR running down from the MSB, purely
// combinational.
module gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    assign bin_o[W-1] = gray_i[W-1];

    generate
        for (genvar gi = W - 2; gi >= 0; gi--) begin : g_prefix
            assign bin_o[gi] = bin_o[gi+1] ^ gray_i[gi];
        end
    endgenerate

endmodule

// File: rtl/gray_count_sequencer.sv
// Run-control sequencer owning a W-bit Gray count register: free-run or
// one-shot stepping, start/stop/hold, parallel load, done and wrap events.
module gray_count_sequencer
    import gray_seq_pkg::*;
#(
    parameter int W = GRAY_W
) (
    input  logic         clk,
    input  logic         c,
    input  logic         start,
    input  logic         stop,
    input  logic         dir,
    input  logic         mode,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] target,
    input  logic         step_en,
    output logic [W-1:0] gray,
    output logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic         wrap
);

    state_t       state_q, state_d;
    logic [W-1:0] gray_q, gray_d;
    logic         mode_q, mode_d;
    logic         wrap_q, wrap_d;

    logic [W-1:0] bin_next;
    logic [W-1:0] gray_next;
    logic         wrap_cond;

    gray2bin #(.W(W)) u_gray2bin (
        .gray_i (gray_q),
        .bin_o  (bin)
    );

    // Step arithmetic is done in binary, then re-encoded so exactly one Gray bit flips.
    always_comb begin
        bin_next  = dir ? (bin - 1'b1) : (bin + 1'b1);
        gray_next = W'(bin2gray(GRAY_MAX_W'(bin_next)));
        wrap_cond = dir ? (bin == '0) : (bin == '1);
    end

    always_comb begin
        state_d = state_q;
        gray_d  = gray_q;
        mode_d  = mode_q;
        wrap_d  = 1'b0;
        if (c) begin
            state_d = ST_IDLE;
            gray_d  = '0;
            mode_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_d  = mode;
                        state_d = (mode && (gray_q == target)) ? ST_DONE : ST_RUN;
                    end else if (load) begin
                        gray_d = load_val;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_HOLD;
                    end else if (step_en) begin
                        gray_d = gray_next;
                        wrap_d = wrap_cond;
                        if (mode_q && (gray_next == target)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (start) begin
                        state_d = ST_RUN;
                    end else if (load) begin
                        gray_d = load_val;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (c) begin
            state_q <= ST_IDLE;
            gray_q  <= '0;
            mode_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gray_q  <= gray_d;
            mode_q  <= mode_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        busy = (state_q == ST_RUN) || (state_q == ST_HOLD);
        done = (state_q == ST_DONE);
        gray = gray_q;
        wrap = wrap_q;
    end

endmodule

// File: tb/tb_gray_count_sequencer.sv
// Directed testbench for gray_count_sequencer: one task per scenario, each
// comparing outputs against hand-computed Gray/binary values.
module tb_gray_count_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         c = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         dir = 1'b0;
    logic         mode = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] target = '0;
    logic         step_en = 1'b0;
    logic [W-1:0] gray;
    logic [W-1:0] bin;
    logic         busy;
    logic         done;
    logic         wrap;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] up_seq [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    gray_count_sequencer #(.W(W)) dut (
        .clk      (clk),
        .c        (c),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .target   (target),
        .step_en  (step_en),
        .gray     (gray),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        c = 1'b1;
        tick();
        c = 1'b0;
    endtask

    task automatic test_reset();
        c = 1'b1;
        tick();
        tick();
        c = 1'b0;
        n_cmp++;
        if ({gray, bin, busy, done, wrap} !== 11'b0) begin
            n_bad++;
            $display("FAIL reset: gray=%b bin=%0d busy=%b done=%b wrap=%b, required all 0",
                     gray, bin, busy, done, wrap);
        end
        $display("reset: gray=%b bin=%0d busy=%b", gray, bin, busy);
    endtask

    task automatic test_free_run_up();
        mode = 1'b0; dir = 1'b0; step_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || gray !== 4'b0000) begin
            n_bad++;
            $display("FAIL up_start: busy=%b gray=%b, required busy=1 gray=0000", busy, gray);
        end
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_cmp++;
            if (gray !== up_seq[i % 16] || bin !== 4'(i % 16) || wrap !== (i == 16)) begin
                n_bad++;
                $display("FAIL up_step%0d: gray=%b bin=%0d wrap=%b, required gray=%b bin=%0d wrap=%b",
                         i, gray, bin, wrap, up_seq[i % 16], i % 16, (i == 16));
            end
            $display("up step %0d: gray=%b bin=%0d wrap=%b", i, gray, bin, wrap);
        end
        tick();
        n_cmp++;
        if (gray !== 4'b0001 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL up_after_wrap: gray=%b wrap=%b, required gray=0001 wrap=0", gray, wrap);
        end
        step_en = 1'b0;
        stop = 1'b1;
        tick();
        tick();
        stop = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || gray !== 4'b0001) begin
            n_bad++;
            $display("FAIL up_stop_idle: busy=%b gray=%b, required busy=0 gray=0001", busy, gray);
        end
    endtask

    task automatic test_down_wrap();
        do_clear();
        mode = 1'b0; dir = 1'b1; step_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        step_en = 1'b1;
        tick();
        step_en = 1'b0;
        n_cmp++;
        if (gray !== 4'b1000 || bin !== 4'd15 || wrap !== 1'b1) begin
            n_bad++;
            $display("FAIL down_wrap: gray=%b bin=%0d wrap=%b, required gray=1000 bin=15 wrap=1",
                     gray, bin, wrap);
        end
        $display("down wrap: gray=%b bin=%0d wrap=%b", gray, bin, wrap);
        tick();
        n_cmp++;
        if (gray !== 4'b1000 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL down_wrap_pulse: gray=%b wrap=%b, required gray=1000 wrap=0", gray, wrap);
        end
        stop = 1'b1;
        tick();
        tick();
        stop = 1'b0;
        dir = 1'b0;
    endtask

    task automatic test_one_shot();
        do_clear();
        target = 4'b1100; mode = 1'b1; dir = 1'b0; step_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        mode = 1'b0;
        for (int i = 1; i <= 7; i++) tick();
        n_cmp++;
        if (gray !== 4'b0100 || done !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL oneshot_step7: gray=%b done=%b busy=%b, required gray=0100 done=0 busy=1",
                     gray, done, busy);
        end
        tick();
        n_cmp++;
        if (gray !== 4'b1100 || done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL oneshot_done: gray=%b done=%b busy=%b, required gray=1100 done=1 busy=0",
                     gray, done, busy);
        end
        $display("one-shot: gray=%b done=%b", gray, done);
        tick();
        n_cmp++;
        if (gray !== 4'b1100 || done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL oneshot_idle: gray=%b done=%b busy=%b, required gray=1100 done=0 busy=0",
                     gray, done, busy);
        end
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (gray !== 4'b1100 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL oneshot_equal: gray=%b done=%b, required gray=1100 done=1", gray, done);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || gray !== 4'b1100) begin
            n_bad++;
            $display("FAIL oneshot_equal_after: done=%b busy=%b gray=%b, required 0 0 1100",
                     done, busy, gray);
        end
        mode = 1'b0; step_en = 1'b0;
    endtask

    task automatic test_stop_hold();
        do_clear();
        mode = 1'b0; dir = 1'b0; step_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++;
        if (gray !== 4'b0010 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_enter: gray=%b busy=%b, required gray=0010 busy=1", gray, busy);
        end
        tick();
        n_cmp++;
        if (gray !== 4'b0010) begin
            n_bad++;
            $display("FAIL hold_frozen: gray=%b, required 0010", gray);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if (gray !== 4'b0110) begin
            n_bad++;
            $display("FAIL hold_resume: gray=%b, required 0110", gray);
        end
        $display("resume: gray=%b busy=%b", gray, busy);
        stop = 1'b1;
        tick();
        tick();
        stop = 1'b0;
        step_en = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || gray !== 4'b0110) begin
            n_bad++;
            $display("FAIL hold_abort: busy=%b gray=%b, required busy=0 gray=0110", busy, gray);
        end
    endtask

    task automatic test_load_gating();
        load = 1'b1; load_val = 4'b1011;
        tick();
        load = 1'b0;
        n_cmp++;
        if (gray !== 4'b1011 || bin !== 4'd13) begin
            n_bad++;
            $display("FAIL load_idle: gray=%b bin=%0d, required gray=1011 bin=13", gray, bin);
        end
        $display("load idle: gray=%b bin=%0d", gray, bin);
        mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        load = 1'b1; load_val = 4'b0000;
        tick();
        load = 1'b0;
        n_cmp++;
        if (gray !== 4'b1011 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL load_run_ignored: gray=%b busy=%b, required gray=1011 busy=1", gray, busy);
        end
        step_en = 1'b1;
        tick();
        step_en = 1'b0;
        n_cmp++;
        if (gray !== 4'b1001 || bin !== 4'd14) begin
            n_bad++;
            $display("FAIL load_then_step: gray=%b bin=%0d, required gray=1001 bin=14", gray, bin);
        end
        stop = 1'b1;
        tick();
        tick();
        stop = 1'b0;
        start = 1'b1; load = 1'b1; load_val = 4'b0101;
        tick();
        start = 1'b0; load = 1'b0;
        n_cmp++;
        if (gray !== 4'b1001 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_load: gray=%b busy=%b, required gray=1001 busy=1", gray, busy);
        end
    endtask

    task automatic test_clear_mid_run();
        do_clear();
        mode = 1'b0; dir = 1'b0; step_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        n_cmp++;
        if (gray !== 4'b0110 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_pre: gray=%b busy=%b, required gray=0110 busy=1", gray, busy);
        end
        c = 1'b1;
        tick();
        c = 1'b0;
        n_cmp++;
        if ({gray, bin, busy, done, wrap} !== 11'b0) begin
            n_bad++;
            $display("FAIL clear_mid_run: gray=%b bin=%0d busy=%b done=%b wrap=%b, required all 0",
                     gray, bin, busy, done, wrap);
        end
        $display("clear mid-run: gray=%b busy=%b", gray, busy);
        tick();
        step_en = 1'b0;
        n_cmp++;
        if (gray !== 4'b0000 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_idle: gray=%b busy=%b, required gray=0000 busy=0", gray, busy);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_free_run_up();
        test_down_wrap();
        test_one_shot();
        test_stop_hold();
        test_load_gating();
        test_clear_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gray_count_sequencer.md
# gray_count_sequencer

Run-control sequencer for the 4-bit SR-flip-flop Gray code counter datapath. It owns the Gray count register and steps it one Gray code per enabled tick, up or down. It runs free-running or one-shot to a programmable target, and supports start, stop/hold and parallel load. It sits between the control/user logic and the counter display/consumers, and emits done and wrap events.

## Interface
- W, 4, counter width in bits; legal range 2..8.
- clk  input  1  rising-edge clock, sole clock.
- c  input  1  clear; synchronous, active-high; highest priority.
- start  input  1  start or resume counting.
- stop  input  1  hold when running; abort to IDLE when holding.
- dir  input  1  0 = count up, 1 = count down; sampled on every step.
- mode  input  1  0 = free-run, 1 = one-shot to target; sampled on start.
- load  input  1  parallel load of load_val; honoured in IDLE/HOLD only.
- load_val  input  W  Gray value to load.
- target  input  W  Gray terminal value for one-shot; sampled each step.
- step_en  input  1  advance tick; one Gray step per cycle high in RUN.
- gray  output  W  current Gray count (registered).
- bin  output  W  binary equivalent of gray (combinational from gray).
- busy  output  1  state is RUN or HOLD.
- done  output  1  one-cycle pulse; one-shot reached target.
- wrap  output  1  one-cycle pulse after a modular wrap step.

## Operation
- States: IDLE, RUN, HOLD, DONE. Mode is latched into a register on an accepted start.
- Priority at each edge: c > stop > start > load > step_en.
- c: state IDLE, gray = 0, latched mode = 0. All outputs are 0: bin = 0, busy = 0, done = 0, wrap = 0. This applies in any state, including mid-RUN.
- IDLE:
  - start, one-shot, gray == target: go to DONE with no step.
  - start otherwise: go to RUN.
  - load without start: gray = load_val.
  - stop: no effect.
- RUN, each cycle with step_en = 1:
  - bin_next = bin + 1 (dir = 0) or bin − 1 (dir = 1), modulo 2^W.
  - gray_next = bin_next ^ (bin_next >> 1).
  - Exactly one bit of gray changes per step.
- RUN, one-shot: if gray_next == target, go to DONE on the same edge.
- RUN, stop: go to HOLD with no step, even if step_en = 1 in that cycle.
- RUN: start and load are ignored.
- HOLD:
  - start: go to RUN.
  - stop: go to IDLE; gray is retained.
  - load: gray = load_val.
  - start and stop together: stop wins.
- DONE: lasts exactly one cycle, then IDLE. Inputs other than c are ignored during DONE.
- Wrap conditions: up from bin 2^W−1 to 0, or down from 0 to 2^W−1. Free-run and one-shot both wrap freely. A one-shot target that is unreachable keeps cycling until stop.

## Timing
- step_en high in cycle n (RUN): gray and bin show the new value in cycle n+1.
- wrap is registered: high in cycle n+1 only.
- done is decoded from state == DONE: high in the cycle after the final step edge, or after the start edge when target is already equal. It is never high for two consecutive cycles.
- busy is decoded from state, so it follows the state with zero latency after each edge.
- Throughput: one step per cycle with step_en held high.
- Load latency: one edge; gray = load_val in the next cycle.
- Latched mode is unaffected by mode changes while in RUN or HOLD.

## Structure
- Package gray_seq_pkg holds:
  - the state enum (IDLE, RUN, HOLD, DONE);
  - a default-width constant GRAY_W = 4;
  - function bin2gray.
- Sub-module gray2bin, parameterised by W: prefix-XOR from the MSB, purely combinational. It drives bin and feeds the step arithmetic.
- Single always block for the state, gray, latched-mode and wrap registers. done and busy are decoded from state.

## Test plan
- **Reset, free-run up.** c for 2 cycles, then start with mode = 0, dir = 0, step_en held high.
  - gray: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - wrap pulses once, on the 1000 -> 0000 step.
  - One bit changes per step; bin = 0..15, then 0.
- **Down wrap.** From 0000, dir = 1, one step -> gray = 1000, bin = 15, wrap = 1 for one cycle.
- **One-shot to target.** target = 1100, mode = 1, start from 0000 with step_en high -> 8 steps.
  - done is high for one cycle with gray = 1100, then IDLE with busy = 0.
  - Start with gray == target -> done next cycle, gray unchanged.
- **Stop, hold, resume.** Stop in RUN -> HOLD with gray frozen even though step_en = 1. Start -> resumes from the same value. Stop in HOLD -> IDLE, busy = 0.
- **Load gating.** load_val = 1011 with load in IDLE -> gray = 1011, bin = 13. load in RUN -> ignored. start + load in IDLE -> RUN with no load.
- **Clear mid-run.** c during RUN at gray = 0110 -> next cycle gray = 0, bin = 0, state IDLE, busy = 0, done = 0, wrap = 0.
